tri_bus_responder: RTL and testbench

//  Far end of the shared half-duplex tri-state data bus driven by a bufif0-style

---
 rtl/tri_bus_responder.sv | 133 +++++++++++++
 tb/tb_tri_bus_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_bus_responder.sv
// Far-end responder on a shared half-duplex tri-state bus: buffers initiator words
// in an RX FIFO and, after a turnaround gap, drives queued response words back.
module tri_bus_responder #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int TURN_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [WIDTH-1:0] bus_data,
    input  logic             bus_en_low,
    output logic             drv_en,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             overflow,
    output logic             collision
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_TURN  = 2'd2,
        S_DRIVE = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   turn_cnt_reg, turn_cnt_next;
    logic            collision_set;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            overflow_reg, collision_reg;

    logic            sample, pop, push, full, drop;

    // The initiator owns the bus whenever its enable is low, so every such cycle is sampled.
    assign sample = ~bus_en_low;
    assign full   = (count_reg == CW'(DEPTH));
    assign pop    = rx_valid & rx_ready;
    assign push   = sample & (~full | pop);
    assign drop   = sample & full & ~pop;

    // Reset gates the driver combinationally so the bus floats the instant rst_n falls.
    assign drv_en   = (state_reg == S_DRIVE) & bus_en_low & tx_valid & rst_n;
    assign tx_ready = drv_en;
    assign bus_data = drv_en ? tx_data : {WIDTH{1'bz}};

    assign rx_valid  = (count_reg != '0);
    assign rx_data   = mem[rd_ptr_reg];
    assign overflow  = overflow_reg;
    assign collision = collision_reg;

    always_comb begin
        state_next    = state_reg;
        turn_cnt_next = turn_cnt_reg;
        collision_set = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!bus_en_low) state_next = S_RECV;
            end
            S_RECV: begin
                if (bus_en_low) begin
                    state_next    = S_TURN;
                    turn_cnt_next = '0;
                end
            end
            S_TURN: begin
                if (!bus_en_low) begin
                    state_next = S_RECV;
                end else if (turn_cnt_reg == TW'(TURN_CYC - 1)) begin
                    state_next = tx_valid ? S_DRIVE : S_IDLE;
                end else begin
                    turn_cnt_next = turn_cnt_reg + 1'b1;
                end
            end
            S_DRIVE: begin
                // Initiator reclaiming the bus wins over an idle tx side.
                if (!bus_en_low) begin
                    state_next    = S_RECV;
                    collision_set = 1'b1;
                end else if (!tx_valid) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            turn_cnt_reg  <= '0;
            collision_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            turn_cnt_reg <= turn_cnt_next;
            if (collision_set) collision_reg <= 1'b1;
            if (drop)          overflow_reg  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage is left unreset; words are kept verbatim, including any X/Z bits.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr_reg] <= bus_data;
    end

endmodule

// File: tb/tb_tri_bus_responder.sv
// Bench for tri_bus_responder: directed vector table, hand sequences for the
// overflow and reset corner cases, then random traffic against a reference model.
module tb_tri_bus_responder;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 4;
    localparam int TURN_CYC = 2;

    logic             clk;
    logic             rst_n;
    wire  [WIDTH-1:0] bus_data;
    logic             bus_en_low;
    logic [WIDTH-1:0] init_data;
    logic             drv_en;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             overflow;
    logic             collision;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // Initiator side of the bus (bufif0-style)
    assign bus_data = bus_en_low ? {WIDTH{1'bz}} : init_data;

    tri_bus_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TURN_CYC(TURN_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_data  (bus_data),
        .bus_en_low(bus_en_low),
        .drv_en    (drv_en),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .overflow  (overflow),
        .collision (collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic             rst_n;
        logic             ben;
        logic [WIDTH-1:0] init;
        logic             txv;
        logic             rdy;
        logic             e_drv;
        logic             e_rv;
        logic [WIDTH-1:0] e_rx;
        logic             e_ovf;
        logic             e_col;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic b, input logic [7:0] i,
                                input logic tv, input logic rd, input logic ed,
                                input logic erv, input logic [7:0] erx,
                                input logic eo, input logic ec);
        vec_t v;
        v.rst_n = r; v.ben = b; v.init = i; v.txv = tv; v.rdy = rd;
        v.e_drv = ed; v.e_rv = erv; v.e_rx = erx; v.e_ovf = eo; v.e_col = ec;
        return v;
    endfunction

    localparam int NVEC = 21;
    vec_t tab [NVEC];

    // Reference model: FIFO as a queue, turnaround as a count of released cycles
    logic [WIDTH-1:0] mq[$];
    bit m_armed, m_drive, m_ovf, m_col;
    int m_run;

    task automatic model_edge();
        bit was_full, do_pop;
        if (!rst_n) begin
            mq.delete();
            m_armed = 0; m_drive = 0; m_ovf = 0; m_col = 0; m_run = 0;
            return;
        end
        was_full = (mq.size() == DEPTH);
        do_pop   = (mq.size() > 0) && rx_ready;
        if (do_pop) void'(mq.pop_front());
        if (!bus_en_low) begin
            if (was_full && !do_pop) m_ovf = 1;
            else mq.push_back(init_data);
            if (m_drive) m_col = 1;
            m_armed = 1; m_run = 0; m_drive = 0;
        end else if (m_drive) begin
            if (!tx_valid) m_drive = 0;
        end else if (m_armed) begin
            m_run++;
            if (m_run == TURN_CYC + 1) begin
                m_armed = 0;
                m_drive = tx_valid;
            end
        end
    endtask

    logic [WIDTH-1:0] drain_exp [4];

    initial begin
        rst_n = 1'b0; bus_en_low = 1'b1; init_data = '0;
        tx_data = 8'h5A; tx_valid = 1'b0; rx_ready = 1'b1;
        drain_exp[0] = 8'h02; drain_exp[1] = 8'h03; drain_exp[2] = 8'h04; drain_exp[3] = 8'h07;

        tab[0]  = mk(1,1,8'h00,0,1, 0,0,8'h00,0,0);
        tab[1]  = mk(1,0,8'hA5,0,1, 0,0,8'h00,0,0);
        tab[2]  = mk(1,0,8'h3C,0,1, 0,1,8'hA5,0,0);
        tab[3]  = mk(1,1,8'h00,1,1, 0,1,8'h3C,0,0);
        tab[4]  = mk(1,1,8'h00,1,1, 0,0,8'h00,0,0);
        tab[5]  = mk(1,1,8'h00,1,1, 0,0,8'h00,0,0);
        tab[6]  = mk(1,1,8'h00,1,1, 1,0,8'h00,0,0);
        tab[7]  = mk(1,1,8'h00,1,1, 1,0,8'h00,0,0);
        tab[8]  = mk(1,1,8'h00,0,1, 0,0,8'h00,0,0);
        tab[9]  = mk(1,0,8'h11,0,1, 0,0,8'h00,0,0);
        tab[10] = mk(1,1,8'h00,0,1, 0,1,8'h11,0,0);
        tab[11] = mk(1,0,8'h22,1,1, 0,0,8'h00,0,0);
        tab[12] = mk(1,1,8'h00,1,1, 0,1,8'h22,0,0);
        tab[13] = mk(1,1,8'h00,1,1, 0,0,8'h00,0,0);
        tab[14] = mk(1,1,8'h00,1,1, 0,0,8'h00,0,0);
        tab[15] = mk(1,1,8'h00,1,1, 1,0,8'h00,0,0);
        tab[16] = mk(1,0,8'hC3,1,1, 0,0,8'h00,0,0);
        tab[17] = mk(1,1,8'h00,0,1, 0,1,8'hC3,0,1);
        tab[18] = mk(1,1,8'h00,0,1, 0,0,8'h00,0,1);
        tab[19] = mk(1,1,8'h00,0,1, 0,0,8'h00,0,1);
        tab[20] = mk(1,1,8'h00,0,1, 0,0,8'h00,0,1);

        repeat (2) @(posedge clk);

        // Directed table: handoff, turnaround abort, collision
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst_n = tab[i].rst_n; bus_en_low = tab[i].ben; init_data = tab[i].init;
            tx_valid = tab[i].txv; rx_ready = tab[i].rdy;
            #1;
            chk($sformatf("vec%0d drv_en", i), drv_en, tab[i].e_drv);
            chk($sformatf("vec%0d tx_ready", i), tx_ready, tab[i].e_drv);
            chk($sformatf("vec%0d rx_valid", i), rx_valid, tab[i].e_rv);
            if (tab[i].e_rv) chk($sformatf("vec%0d rx_data", i), rx_data, tab[i].e_rx);
            chk($sformatf("vec%0d overflow", i), overflow, tab[i].e_ovf);
            chk($sformatf("vec%0d collision", i), collision, tab[i].e_col);
            if (tab[i].e_drv) chk($sformatf("vec%0d bus_resp", i), bus_data, tx_data);
            if (!tab[i].ben)  chk($sformatf("vec%0d bus_init", i), bus_data, tab[i].init);
            $display("vec %0d: ben=%0b init=%02h txv=%0b -> drv=%0b rv=%0b rx=%02h ovf=%0b col=%0b",
                     i, bus_en_low, init_data, tx_valid, drv_en, rx_valid, rx_data, overflow, collision);
            @(posedge clk);
        end

        // Overflow: six words into a four-deep FIFO with no consumer
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            bus_en_low = 1'b0; init_data = 8'(i); rx_ready = 1'b0; tx_valid = 1'b0;
            #1;
            if (i == 5) chk("full_no_ovf", overflow, 1'b0);
            if (i == 6) chk("ovf_set", overflow, 1'b1);
            $display("fill %0d: word=%02h ovf=%0b", i, init_data, overflow);
            @(posedge clk);
        end
        @(negedge clk);
        bus_en_low = 1'b0; init_data = 8'h07; rx_ready = 1'b1;
        #1;
        chk("full_head", rx_data, 8'h01);
        chk("full_valid", rx_valid, 1'b1);
        $display("pop+push at full: head=%02h new=%02h", rx_data, init_data);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_en_low = 1'b1; rx_ready = 1'b1;
            #1;
            chk($sformatf("drain%0d", i), rx_data, drain_exp[i]);
            $display("drain %0d: rx=%02h", i, rx_data);
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        chk("drained_empty", rx_valid, 1'b0);

        // Reset in the middle of a drive
        @(negedge clk);
        bus_en_low = 1'b0; init_data = 8'hAA; rx_ready = 1'b0; tx_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus_en_low = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("pre_rst_drv", drv_en, 1'b1);
        chk("pre_rst_bus", bus_data, 8'h5A);
        chk("pre_rst_rv", rx_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_drv_gate", drv_en, 1'b0);
        chk("rst_txr_gate", tx_ready, 1'b0);
        $display("reset mid-drive: drv=%0b", drv_en);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; tx_valid = 1'b0;
        #1;
        chk("post_rst_rv", rx_valid, 1'b0);
        chk("post_rst_ovf", overflow, 1'b0);
        chk("post_rst_col", collision, 1'b0);
        chk("post_rst_drv", drv_en, 1'b0);
        $display("after reset: rv=%0b ovf=%0b col=%0b", rx_valid, overflow, collision);

        // Random traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            bit exp_drv;
            @(negedge clk);
            rst_n = (c < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0) bus_en_low = ~bus_en_low;
            init_data = 8'($urandom);
            tx_data   = 8'($urandom);
            tx_valid  = ($urandom_range(0, 3) != 0);
            rx_ready  = 1'($urandom_range(0, 1));
            #1;
            if (c >= 2) begin
                exp_drv = m_drive && bus_en_low && tx_valid && rst_n;
                chk($sformatf("rnd%0d drv_en", c), drv_en, exp_drv);
                chk($sformatf("rnd%0d tx_ready", c), tx_ready, exp_drv);
                chk($sformatf("rnd%0d rx_valid", c), rx_valid, mq.size() > 0);
                if (mq.size() > 0) chk($sformatf("rnd%0d rx_data", c), rx_data, mq[0]);
                chk($sformatf("rnd%0d overflow", c), overflow, m_ovf);
                chk($sformatf("rnd%0d collision", c), collision, m_col);
                if (exp_drv) chk($sformatf("rnd%0d bus", c), bus_data, tx_data);
                $display("rnd %0d: rst=%0b ben=%0b txv=%0b rdy=%0b drv=%0b rv=%0b rx=%02h ovf=%0b col=%0b",
                         c, rst_n, bus_en_low, tx_valid, rx_ready, drv_en, rx_valid, rx_data,
                         overflow, collision);
            end
            @(posedge clk);
            model_edge();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
